// File: rtl/ysyx_25040129_wb_sched.sv
// ============================================================================
//  Module   : ysyx_25040129_wb_sched
//  Purpose  : ALU/LSU writeback arbiter sharing one regfile write port, with a
//             per-register busy scoreboard stalling issue on RAW/WAW hazards.
//             Define YSYX_25040129_WB_PERF_EN to add stall/conflict counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_25040129_wb_sched #(
  parameter int REGS_DIG = 4,
  parameter int XLEN     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic                     issue_wen,
  input  logic [REGS_DIG-1:0]      issue_rd,
  input  logic [REGS_DIG-1:0]      issue_rs1,
  input  logic [REGS_DIG-1:0]      issue_rs2,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REGS_DIG-1:0]      alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [REGS_DIG-1:0]      lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  output logic                     reg_write,
  output logic [REGS_DIG-1:0]      rd,
  output logic [XLEN-1:0]          result,
  output logic [(1<<REGS_DIG)-1:0] busy_vec
`ifdef YSYX_25040129_WB_PERF_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              conflict_cnt
`endif
);

  localparam int NREG = 1 << REGS_DIG;

  logic [NREG-1:0]     busy_q, busy_d;
  logic                ptr_q, ptr_d;      // 0: ALU wins next contention, 1: LSU
  logic                reg_write_q, reg_write_d;
  logic [REGS_DIG-1:0] rd_q, rd_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic rs1_hz, rs2_hz, rd_hz, issue_fire;
  logic alu_gnt, lsu_gnt;

  assign rs1_hz      = (issue_rs1 != '0) & busy_q[issue_rs1];
  assign rs2_hz      = (issue_rs2 != '0) & busy_q[issue_rs2];
  assign rd_hz       = issue_wen & (issue_rd != '0) & busy_q[issue_rd];
  assign issue_ready = ~(rs1_hz | rs2_hz | rd_hz);
  assign issue_fire  = issue_valid & issue_ready;

  assign alu_gnt   = alu_valid & (~lsu_valid | ~ptr_q);
  assign lsu_gnt   = lsu_valid & (~alu_valid | ptr_q);
  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;

  always_comb begin
    ptr_d       = ptr_q;
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    result_d    = result_q;
    busy_d      = busy_q;

    if (alu_valid & lsu_valid) begin
      ptr_d = ~ptr_q;
    end

    if (alu_gnt) begin
      reg_write_d = (alu_rd != '0);
      rd_d        = alu_rd;
      result_d    = alu_data;
    end else if (lsu_gnt) begin
      reg_write_d = (lsu_rd != '0);
      rd_d        = lsu_rd;
      result_d    = lsu_data;
    end

    // Clear on commit first so a same-index set wins.
    if (reg_write_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (issue_fire & issue_wen & (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      ptr_q       <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      result_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
    end
  end

  assign reg_write = reg_write_q;
  assign rd        = rd_q;
  assign result    = result_q;
  assign busy_vec  = busy_q;

`ifdef YSYX_25040129_WB_PERF_EN
  logic [31:0] stall_cnt_q, conflict_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (issue_valid & ~issue_ready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (alu_valid & lsu_valid) begin
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25040129_wb_sched.sv
// ============================================================================
//  Testbench : tb_ysyx_25040129_wb_sched
//  Purpose   : table-driven vectors plus hand sequences for reset and fairness.
// ============================================================================
`default_nettype none

module tb_ysyx_25040129_wb_sched;

  typedef struct {
    logic        iv, iw;
    logic [3:0]  ird, irs1, irs2;
    logic        av;
    logic [3:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [3:0]  lrd;
    logic [31:0] ld;
    logic        e_ir, e_ar, e_lr, e_wr;
    logic [3:0]  e_rd;
    logic [31:0] e_res;
    logic [15:0] e_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready, issue_wen;
  logic [3:0]  issue_rd, issue_rs1, issue_rs2;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [3:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        reg_write;
  logic [3:0]  rd;
  logic [31:0] result;
  logic [15:0] busy_vec;
`ifdef YSYX_25040129_WB_PERF_EN
  logic [31:0] stall_cnt, conflict_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int stall_exp = 0;
  int conf_exp = 0;

  always #5 clk = ~clk;

  ysyx_25040129_wb_sched #(.REGS_DIG(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .reg_write(reg_write), .rd(rd), .result(result), .busy_vec(busy_vec)
`ifdef YSYX_25040129_WB_PERF_EN
    , .stall_cnt(stall_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Any commit to a register that is not marked busy is a protocol error.
  task automatic protocol_chk();
    if (reg_write && rd != 4'd0) chk("protocol_busy_on_commit", 32'(busy_vec[rd]), 32'd1);
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_wen = 1'b0;
    issue_rd = 4'd0; issue_rs1 = 4'd0; issue_rs2 = 4'd0;
    alu_valid = 1'b0; alu_rd = 4'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 4'd0; lsu_data = 32'd0;
  endtask

  function automatic vec_t mk(input int iv, input int iw, input int ird, input int irs1,
                              input int irs2, input int av, input int ard, input logic [31:0] ad,
                              input int lv, input int lrd, input logic [31:0] ld,
                              input int e_ir, input int e_ar, input int e_lr, input int e_wr,
                              input int e_rd, input logic [31:0] e_res, input logic [15:0] e_busy);
    vec_t v;
    v.iv = 1'(iv); v.iw = 1'(iw); v.ird = 4'(ird); v.irs1 = 4'(irs1); v.irs2 = 4'(irs2);
    v.av = 1'(av); v.ard = 4'(ard); v.ad = ad;
    v.lv = 1'(lv); v.lrd = 4'(lrd); v.ld = ld;
    v.e_ir = 1'(e_ir); v.e_ar = 1'(e_ar); v.e_lr = 1'(e_lr); v.e_wr = 1'(e_wr);
    v.e_rd = 4'(e_rd); v.e_res = e_res; v.e_busy = e_busy;
    return v;
  endfunction

  vec_t vecs[19];

  initial begin
    logic [3:0]  alist [3];
    logic [3:0]  llist [3];
    int          ai, li;
    logic        p;
    logic [3:0]  wrd;

    //          iv iw ird rs1 rs2 av ard ad           lv lrd ld     ir ar lr wr rd res          busy
    vecs[0]  = mk(1, 1, 3, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 0, 0, 0, 32'h0,        16'h0008);
    vecs[1]  = mk(1, 0, 0, 3, 0,  0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h0,        16'h0008);
    vecs[2]  = mk(1, 0, 0, 3, 0,  1, 3, 32'hDEADBEEF, 0, 0, 32'h0,  0, 1, 0, 1, 3, 32'hDEADBEEF, 16'h0008);
    vecs[3]  = mk(1, 0, 0, 3, 0,  0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0, 3, 32'hDEADBEEF, 16'h0000);
    vecs[4]  = mk(1, 0, 0, 3, 0,  0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 0, 0, 3, 32'hDEADBEEF, 16'h0000);
    vecs[5]  = mk(1, 1, 1, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 0, 0, 3, 32'hDEADBEEF, 16'h0002);
    vecs[6]  = mk(1, 1, 2, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 0, 0, 3, 32'hDEADBEEF, 16'h0006);
    vecs[7]  = mk(0, 0, 0, 0, 0,  1, 1, 32'h11,       1, 2, 32'h22, 1, 1, 0, 1, 1, 32'h11,       16'h0006);
    vecs[8]  = mk(0, 0, 0, 0, 0,  0, 0, 32'h0,        1, 2, 32'h22, 1, 0, 1, 1, 2, 32'h22,       16'h0004);
    vecs[9]  = mk(0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 0, 0, 2, 32'h22,       16'h0000);
    vecs[10] = mk(1, 1, 7, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 0, 0, 2, 32'h22,       16'h0080);
    vecs[11] = mk(1, 1, 7, 0, 0,  0, 0, 32'h0,        1, 7, 32'h77, 0, 0, 1, 1, 7, 32'h77,       16'h0080);
    vecs[12] = mk(1, 1, 7, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0, 7, 32'h77,       16'h0000);
    vecs[13] = mk(1, 1, 7, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 0, 0, 7, 32'h77,       16'h0080);
    vecs[14] = mk(1, 1, 0, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 0, 0, 7, 32'h77,       16'h0080);
    vecs[15] = mk(0, 0, 0, 0, 0,  1, 0, 32'h55,       0, 0, 32'h0,  1, 1, 0, 0, 0, 32'h55,       16'h0080);
    vecs[16] = mk(1, 0, 7, 0, 0,  0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 0, 0, 0, 32'h55,       16'h0080);
    vecs[17] = mk(1, 0, 0, 0, 7,  0, 0, 32'h0,        1, 7, 32'h70, 0, 0, 1, 1, 7, 32'h70,       16'h0080);
    vecs[18] = mk(1, 0, 0, 0, 7,  0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0, 7, 32'h70,       16'h0000);

    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy_vec), 32'h0);
    chk("reset_reg_write", 32'(reg_write), 32'h0);
    chk("reset_rd", 32'(rd), 32'h0);
    chk("reset_result", result, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      issue_valid = vecs[i].iv; issue_wen = vecs[i].iw; issue_rd = vecs[i].ird;
      issue_rs1 = vecs[i].irs1; issue_rs2 = vecs[i].irs2;
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
      lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ld;
      #1;
      chk($sformatf("v%0d_issue_ready", i), 32'(issue_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
      chk($sformatf("v%0d_lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].e_lr));
      if (vecs[i].iv && !vecs[i].e_ir) stall_exp++;
      if (vecs[i].av && vecs[i].lv) conf_exp++;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_reg_write", i), 32'(reg_write), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_rd", i), 32'(rd), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_result", i), result, vecs[i].e_res);
      chk($sformatf("v%0d_busy_vec", i), 32'(busy_vec), 32'(vecs[i].e_busy));
      protocol_chk();
    end
`ifdef YSYX_25040129_WB_PERF_EN
    chk("table_stall_cnt", stall_cnt, 32'(stall_exp));
    chk("table_conflict_cnt", conflict_cnt, 32'(conf_exp));
`endif

    // Reset while a commit is pending and a register is busy.
    @(negedge clk);
    idle_inputs();
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 4'd5;
    @(negedge clk);
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 32'hAB;
    @(posedge clk);
    #1;
    chk("pre_reset_reg_write", 32'(reg_write), 32'd1);
    chk("pre_reset_busy", 32'(busy_vec), 32'h0020);
    #2;
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("async_reset_busy", 32'(busy_vec), 32'h0);
    chk("async_reset_reg_write", 32'(reg_write), 32'h0);
    chk("async_reset_rd", 32'(rd), 32'h0);
    chk("async_reset_result", result, 32'h0);
`ifdef YSYX_25040129_WB_PERF_EN
    chk("async_reset_stall_cnt", stall_cnt, 32'h0);
    chk("async_reset_conflict_cnt", conflict_cnt, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Mark 1,2,4,5,6,8 busy, then hold both sources valid for 6 cycles.
    alist = '{4'd1, 4'd4, 4'd6};
    llist = '{4'd2, 4'd5, 4'd8};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      idle_inputs();
      issue_valid = 1'b1; issue_wen = 1'b1;
      issue_rd = (k % 2 == 0) ? alist[k/2] : llist[k/2];
      #1;
      chk($sformatf("fair_issue%0d_ready", k), 32'(issue_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    chk("fair_busy_set", 32'(busy_vec), 32'h0176);

    ai = 0; li = 0; p = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      idle_inputs();
      alu_valid = 1'b1; alu_rd = alist[ai % 3]; alu_data = 32'h11 * 32'(alist[ai % 3]);
      lsu_valid = 1'b1; lsu_rd = llist[li % 3]; lsu_data = 32'h11 * 32'(llist[li % 3]);
      #1;
      chk($sformatf("fair%0d_alu_ready", k), 32'(alu_ready), 32'(!p));
      chk($sformatf("fair%0d_lsu_ready", k), 32'(lsu_ready), 32'(p));
      wrd = p ? llist[li % 3] : alist[ai % 3];
      @(posedge clk);
      #1;
      chk($sformatf("fair%0d_reg_write", k), 32'(reg_write), 32'd1);
      chk($sformatf("fair%0d_rd", k), 32'(rd), 32'(wrd));
      chk($sformatf("fair%0d_result", k), result, 32'h11 * 32'(wrd));
      protocol_chk();
      if (p) li++; else ai++;
      p = ~p;
    end
    @(negedge clk);
    idle_inputs();
`ifdef YSYX_25040129_WB_PERF_EN
    chk("fair_conflict_cnt", conflict_cnt, 32'd6);
    chk("fair_stall_cnt", stall_cnt, 32'd0);
`endif
    repeat (2) @(negedge clk);
    chk("fair_busy_drained", 32'(busy_vec), 32'h0);
    chk("fair_idle_reg_write", 32'(reg_write), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
